pwm_duty_ramp_ctrl: RTL and testbench

Soft-start/soft-stop controller for the 4-bit PWM generator: accepts a target duty through a valid/ready handshake and slews the generator's `pulse_width` toward it in bounded steps. Steps are applied only at PWM period boundaries. Sits between the motor-command logic and the PWM generator in the `clk_50MHz` domain, driving `pulse_width` directly. Includes an emergency-stop path that forces zero duty.

---
 rtl/pwm_duty_ramp_ctrl.sv | 128 ++++++++++++
 tb/tb_pwm_duty_ramp_ctrl.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/pwm_duty_ramp_ctrl.sv
// Soft-start/stop duty slewer for the 4-bit PWM: latches a target over valid/ready and steps pulse_width toward it at period boundaries.
// One-clock output latency; target_ready is low while ramping or stopped, so the requester holds target_valid until IDLE.
module pwm_duty_ramp_ctrl #(
  parameter int STEP_PERIODS = 4,
  parameter int STEP_SIZE    = 1,
  parameter int DUTY_MAX     = 15
) (
  input  logic       clk_50MHz,
  input  logic       reset,
  input  logic       period_start,
  input  logic       estop,
  input  logic       target_valid,
  input  logic [3:0] target_duty,
  output logic       target_ready,
  output logic [3:0] pulse_width,
  output logic       ramp_busy,
  output logic       at_target
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RAMP  = 2'd1,
    ST_FAULT = 2'd2
  } state_t;

  localparam logic [7:0] CNT_LAST = 8'(STEP_PERIODS - 1);
  localparam logic [4:0] STEP5    = 5'(STEP_SIZE);
  localparam logic [3:0] DMAX     = 4'(DUTY_MAX);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [3:0]  tgt_q, tgt_d;
  logic [3:0]  pw_q, pw_d;
  logic        busy_q, busy_d;
  logic        at_q, at_d;
  logic        rdy_q, rdy_d;

  logic [3:0]        req_clamped;
  logic signed [4:0] diff;
  logic [4:0]        mag;
  logic [3:0]        step_amt;
  logic [3:0]        pw_stepped;

  // Step is limited to the remaining distance, so the ramp lands exactly on tgt.
  always_comb begin
    req_clamped = (target_duty > DMAX) ? DMAX : target_duty;
    diff        = $signed({1'b0, tgt_q}) - $signed({1'b0, pw_q});
    mag         = diff[4] ? 5'(-diff) : 5'(diff);
    step_amt    = (mag > STEP5) ? STEP5[3:0] : mag[3:0];
    pw_stepped  = diff[4] ? (pw_q - step_amt) : (pw_q + step_amt);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tgt_d   = tgt_q;
    pw_d    = pw_q;
    at_d    = 1'b0;
    if (estop) begin
      state_d = ST_FAULT;
      pw_d    = 4'd0;
      tgt_d   = 4'd0;
      cnt_d   = 8'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (target_valid && rdy_q) begin
            tgt_d = req_clamped;
            cnt_d = 8'd0;
            if (req_clamped == pw_q) begin
              at_d = 1'b1;
            end else begin
              state_d = ST_RAMP;
            end
          end
        end
        ST_RAMP: begin
          if (period_start) begin
            if (cnt_q == CNT_LAST) begin
              cnt_d = 8'd0;
              pw_d  = pw_stepped;
              if (pw_stepped == tgt_q) begin
                state_d = ST_IDLE;
                at_d    = 1'b1;
              end
            end else begin
              cnt_d = cnt_q + 8'd1;
            end
          end
        end
        ST_FAULT: begin
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
    busy_d = (state_d == ST_RAMP);
    rdy_d  = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk_50MHz) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= 8'd0;
      tgt_q   <= 4'd0;
      pw_q    <= 4'd0;
      busy_q  <= 1'b0;
      at_q    <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tgt_q   <= tgt_d;
      pw_q    <= pw_d;
      busy_q  <= busy_d;
      at_q    <= at_d;
      rdy_q   <= rdy_d;
    end
  end

  assign target_ready = rdy_q;
  assign pulse_width  = pw_q;
  assign ramp_busy    = busy_q;
  assign at_target    = at_q;

endmodule

// File: tb/tb_pwm_duty_ramp_ctrl.sv
// Directed bench for pwm_duty_ramp_ctrl: default, STEP_SIZE=3 and DUTY_MAX=12 instances share one stimulus stream.
module tb_pwm_duty_ramp_ctrl;

  logic       clk_50MHz = 1'b0;
  logic       reset = 1'b1;
  logic       period_start = 1'b0;
  logic       estop = 1'b0;
  logic       target_valid = 1'b0;
  logic [3:0] target_duty = 4'd0;

  logic       d_rdy, s_rdy, c_rdy;
  logic [3:0] d_pw, s_pw, c_pw;
  logic       d_busy, s_busy, c_busy;
  logic       d_at, s_at, c_at;

  int n_assert = 0;
  int n_fail   = 0;

  always #10 clk_50MHz = ~clk_50MHz;

  pwm_duty_ramp_ctrl u_def (
    .clk_50MHz(clk_50MHz), .reset(reset), .period_start(period_start), .estop(estop),
    .target_valid(target_valid), .target_duty(target_duty), .target_ready(d_rdy),
    .pulse_width(d_pw), .ramp_busy(d_busy), .at_target(d_at)
  );

  pwm_duty_ramp_ctrl #(.STEP_SIZE(3)) u_s3 (
    .clk_50MHz(clk_50MHz), .reset(reset), .period_start(period_start), .estop(estop),
    .target_valid(target_valid), .target_duty(target_duty), .target_ready(s_rdy),
    .pulse_width(s_pw), .ramp_busy(s_busy), .at_target(s_at)
  );

  pwm_duty_ramp_ctrl #(.DUTY_MAX(12)) u_c12 (
    .clk_50MHz(clk_50MHz), .reset(reset), .period_start(period_start), .estop(estop),
    .target_valid(target_valid), .target_duty(target_duty), .target_ready(c_rdy),
    .pulse_width(c_pw), .ramp_busy(c_busy), .at_target(c_at)
  );

  task automatic tick();
    @(posedge clk_50MHz);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic pstart();
    period_start = 1'b1;
    tick();
    period_start = 1'b0;
  endtask

  task automatic accept(input logic [3:0] duty);
    target_valid = 1'b1;
    target_duty  = duty;
    tick();
    target_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
  endtask

  initial begin
    logic [3:0] exp_pw;

    // reset held for 3 cycles
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_pw", 8'(d_pw), 8'd0);
      chk("rst_rdy", 8'(d_rdy), 8'd0);
      chk("rst_busy", 8'(d_busy), 8'd0);
    end
    reset = 1'b0;
    tick();
    chk("rel_rdy", 8'(d_rdy), 8'd1);
    chk("rel_at", 8'(d_at), 8'd0);

    // ramp up 0 -> 8, with a period_start in the accept cycle that must not count
    target_valid = 1'b1;
    target_duty  = 4'd8;
    period_start = 1'b1;
    tick();
    target_valid = 1'b0;
    period_start = 1'b0;
    chk("up_busy", 8'(d_busy), 8'd1);
    chk("up_rdy", 8'(d_rdy), 8'd0);
    chk("up_pw0", 8'(d_pw), 8'd0);
    for (int k = 1; k <= 32; k++) begin
      pstart();
      chk("up_pw", 8'(d_pw), 8'(k / 4));
      chk("up_at", 8'(d_at), (k == 32) ? 8'd1 : 8'd0);
      chk("up_busy_k", 8'(d_busy), (k == 32) ? 8'd0 : 8'd1);
      tick();
      chk("up_at_off", 8'(d_at), 8'd0);
    end
    chk("up_rdy_end", 8'(d_rdy), 8'd1);

    // ramp down with STEP_SIZE=3: reach 12, then 12 -> 9 -> 6 -> 5
    do_reset();
    accept(4'd12);
    for (int k = 1; k <= 16; k++) begin
      pstart();
      tick();
    end
    chk("dn_start_pw", 8'(s_pw), 8'd12);
    chk("dn_start_rdy", 8'(s_rdy), 8'd1);
    accept(4'd5);
    chk("dn_busy", 8'(s_busy), 8'd1);
    for (int k = 1; k <= 12; k++) begin
      pstart();
      exp_pw = (k < 4) ? 4'd12 : (k < 8) ? 4'd9 : (k < 12) ? 4'd6 : 4'd5;
      chk("dn_pw", 8'(s_pw), 8'(exp_pw));
      chk("dn_at", 8'(s_at), (k == 12) ? 8'd1 : 8'd0);
      tick();
    end
    chk("dn_busy_end", 8'(s_busy), 8'd0);

    // clamp with DUTY_MAX=12: target 15 stops at 12
    do_reset();
    accept(4'd15);
    for (int k = 1; k <= 48; k++) begin
      pstart();
      chk("clamp_at", 8'(c_at), (k == 48) ? 8'd1 : 8'd0);
      tick();
    end
    chk("clamp_pw", 8'(c_pw), 8'd12);
    chk("clamp_busy", 8'(c_busy), 8'd0);
    for (int k = 1; k <= 8; k++) begin
      pstart();
      tick();
    end
    chk("clamp_hold", 8'(c_pw), 8'd12);
    accept(4'd12);
    chk("eq_at", 8'(c_at), 8'd1);
    chk("eq_busy", 8'(c_busy), 8'd0);
    chk("eq_rdy", 8'(c_rdy), 8'd1);
    tick();
    chk("eq_at_off", 8'(c_at), 8'd0);

    // estop mid-ramp at pulse_width 6 during ramp to 10
    do_reset();
    accept(4'd10);
    for (int k = 1; k <= 24; k++) begin
      pstart();
      tick();
    end
    chk("es_pre_pw", 8'(d_pw), 8'd6);
    estop = 1'b1;
    tick();
    chk("es_pw", 8'(d_pw), 8'd0);
    chk("es_rdy", 8'(d_rdy), 8'd0);
    chk("es_busy", 8'(d_busy), 8'd0);
    chk("es_at", 8'(d_at), 8'd0);
    target_valid = 1'b1;
    target_duty  = 4'd9;
    pstart();
    target_valid = 1'b0;
    chk("es_hold_pw", 8'(d_pw), 8'd0);
    chk("es_hold_rdy", 8'(d_rdy), 8'd0);
    estop = 1'b0;
    tick();
    chk("es_rel_rdy", 8'(d_rdy), 8'd1);
    chk("es_rel_pw", 8'(d_pw), 8'd0);
    for (int k = 1; k <= 4; k++) begin
      pstart();
      tick();
    end
    chk("es_disc_pw", 8'(d_pw), 8'd0);
    chk("es_disc_busy", 8'(d_busy), 8'd0);

    // reset mid-ramp at pulse_width 7, then target 3 ramps from 0
    accept(4'd10);
    for (int k = 1; k <= 28; k++) begin
      pstart();
      tick();
    end
    chk("mr_pre_pw", 8'(d_pw), 8'd7);
    reset = 1'b1;
    tick();
    chk("mr_pw", 8'(d_pw), 8'd0);
    chk("mr_busy", 8'(d_busy), 8'd0);
    chk("mr_rdy", 8'(d_rdy), 8'd0);
    chk("mr_at", 8'(d_at), 8'd0);
    reset = 1'b0;
    tick();
    chk("mr_rel_rdy", 8'(d_rdy), 8'd1);
    accept(4'd3);
    for (int k = 1; k <= 12; k++) begin
      pstart();
      chk("mr_pw_k", 8'(d_pw), 8'(k / 4));
      chk("mr_at_k", 8'(d_at), (k == 12) ? 8'd1 : 8'd0);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
